// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and width defaults for the shared ALU
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int OPW_DEFAULT   = 5;

  localparam int OP_ADD       = 0;
  localparam int OP_SUB       = 1;
  localparam int OP_AND       = 2;
  localparam int OP_OR        = 3;
  localparam int OP_SLL       = 4;
  localparam int OP_SRA       = 5;
  localparam int OP_MAX_LEGAL = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_is_legal(input int op);
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle for the two ALU requesters
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = OPW_DEFAULT
);
  logic             req_valid_0, req_valid_1;
  logic             req_ready_0, req_ready_1;
  logic [OPW-1:0]   req_op_0, req_op_1;
  logic [OPW-1:0]   req_shamt_0, req_shamt_1;
  logic [WIDTH-1:0] req_a_0, req_a_1;
  logic [WIDTH-1:0] req_b_0, req_b_1;
  logic             resp_valid_0, resp_valid_1;
  logic             resp_ready_0, resp_ready_1;
  logic [WIDTH-1:0] resp_result;
  logic             resp_ne, resp_lt, resp_ovf, resp_err;

  modport master (
    output req_valid_0, req_valid_1, req_op_0, req_op_1, req_shamt_0, req_shamt_1,
           req_a_0, req_a_1, req_b_0, req_b_1, resp_ready_0, resp_ready_1,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
           resp_result, resp_ne, resp_lt, resp_ovf, resp_err
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_op_0, req_op_1, req_shamt_0, req_shamt_1,
           req_a_0, req_a_1, req_b_0, req_b_1, resp_ready_0, resp_ready_1,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
           resp_result, resp_ne, resp_lt, resp_ovf, resp_err
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational datapath ALU: add, sub, and, or, sll, sra plus compare/overflow flags
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic [OPW-1:0]   op,
  input  logic [OPW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             is_not_equal,
  output logic             is_less_than,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum  = a + b;
  assign diff = a - b;

  // Signed overflow: operand signs agree (add) or differ (sub) and the result sign flips.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  assign overflow     = (int'(op) == OP_SUB) ? sub_ovf : add_ovf;
  assign is_not_equal = (a != b);
  assign is_less_than = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (int'(op))
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = $signed(a) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters, one op in flight
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [OPW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ne_q, ne_d;
  logic             lt_q, lt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             grant;
  logic             accept;
  logic             resp_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ne, alu_lt, alu_ovf;

  alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .op           (op_q),
    .shamt        (shamt_q),
    .a            (a_q),
    .b            (b_q),
    .result       (alu_result),
    .is_not_equal (alu_ne),
    .is_less_than (alu_lt),
    .overflow     (alu_ovf)
  );

  always_comb begin
    grant = 1'b0;
    if (bus.req_valid_0 && bus.req_valid_1) begin
      grant = ~last_grant_q;
    end else if (bus.req_valid_1) begin
      grant = 1'b1;
    end
  end

  // Gated by reset so that ready reads low while reset is held, whatever req_valid does.
  assign bus.req_ready_0 = reset && (state_q == IDLE) && bus.req_valid_0 && !grant;
  assign bus.req_ready_1 = reset && (state_q == IDLE) && bus.req_valid_1 && grant;
  assign accept          = bus.req_ready_0 || bus.req_ready_1;

  assign bus.resp_valid_0 = (state_q == RESP) && !owner_q;
  assign bus.resp_valid_1 = (state_q == RESP) && owner_q;
  assign resp_done        = owner_q ? bus.resp_ready_1 : bus.resp_ready_0;

  assign bus.resp_result = result_q;
  assign bus.resp_ne     = ne_q;
  assign bus.resp_lt     = lt_q;
  assign bus.resp_ovf    = ovf_q;
  assign bus.resp_err    = err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    shamt_d      = shamt_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    ne_d         = ne_q;
    lt_d         = lt_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          op_d         = grant ? bus.req_op_1    : bus.req_op_0;
          shamt_d      = grant ? bus.req_shamt_1 : bus.req_shamt_0;
          a_d          = grant ? bus.req_a_1     : bus.req_a_0;
          b_d          = grant ? bus.req_b_1     : bus.req_b_0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // Illegal opcodes report zeros rather than whatever the ALU mux defaults to.
        if (op_is_legal(int'(op_q))) begin
          result_d = alu_result;
          ne_d     = alu_ne;
          lt_d     = alu_lt;
          ovf_d    = alu_ovf;
          err_d    = 1'b0;
        end else begin
          result_d = '0;
          ne_d     = 1'b0;
          lt_d     = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      shamt_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      ne_q         <= 1'b0;
      lt_q         <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      shamt_q      <= shamt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      ne_q         <= ne_d;
      lt_q         <= lt_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  alu_arbiter_if #(.WIDTH(32), .OPW(5)) bus ();

  alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int last_grant;

  logic        v  [2];
  logic [4:0]  op [2];
  logic [4:0]  sh [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];
  logic        rr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid_0  = v[0];   bus.req_valid_1  = v[1];
    bus.req_op_0     = op[0];  bus.req_op_1     = op[1];
    bus.req_shamt_0  = sh[0];  bus.req_shamt_1  = sh[1];
    bus.req_a_0      = a[0];   bus.req_a_1      = a[1];
    bus.req_b_0      = b[0];   bus.req_b_1      = b[1];
    bus.resp_ready_0 = rr[0];  bus.resp_ready_1 = rr[1];
  endtask

  task automatic set_req(input int x, input logic [4:0] o, input logic [4:0] s,
                         input logic [31:0] aa, input logic [31:0] bb);
    v[x] = 1'b1; op[x] = o; sh[x] = s; a[x] = aa; b[x] = bb;
  endtask

  // Reference: two's-complement semantics evaluated in 64-bit signed arithmetic.
  function automatic void model(input logic [4:0] o, input logic [4:0] s,
                                input logic [31:0] aa, input logic [31:0] bb,
                                output logic [31:0] r, output logic ne, output logic lt,
                                output logic ov, output logic er);
    longint sa = longint'($signed(aa));
    longint sb = longint'($signed(bb));
    longint t;
    er = (o > 5);
    r = 0; ne = 0; lt = 0; ov = 0;
    if (!er) begin
      ne = (aa != bb);
      lt = (sa < sb);
      t  = (o == 1) ? sa - sb : sa + sb;
      ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      case (o)
        5'd0:    r = aa + bb;
        5'd1:    r = aa - bb;
        5'd2:    r = aa & bb;
        5'd3:    r = aa | bb;
        5'd4:    r = aa << s;
        default: r = $signed(aa) >>> s;
      endcase
    end
  endfunction

  task automatic chk_quiet(input string pfx);
    chk({pfx, " req_ready_0"},  bus.req_ready_0,  0);
    chk({pfx, " req_ready_1"},  bus.req_ready_1,  0);
    chk({pfx, " resp_valid_0"}, bus.resp_valid_0, 0);
    chk({pfx, " resp_valid_1"}, bus.resp_valid_1, 0);
    chk({pfx, " resp_result"},  bus.resp_result,  0);
    chk({pfx, " resp_ne"},      bus.resp_ne,      0);
    chk({pfx, " resp_lt"},      bus.resp_lt,      0);
    chk({pfx, " resp_ovf"},     bus.resp_ovf,     0);
    chk({pfx, " resp_err"},     bus.resp_err,     0);
  endtask

  task automatic chk_resp(input int w, input logic [31:0] er, input logic en, input logic el,
                          input logic eo, input logic ee);
    chk("resp_valid_owner", w ? bus.resp_valid_1 : bus.resp_valid_0, 1);
    chk("resp_valid_other", w ? bus.resp_valid_0 : bus.resp_valid_1, 0);
    chk("resp_result", bus.resp_result, er);
    chk("resp_ne",     bus.resp_ne,     en);
    chk("resp_lt",     bus.resp_lt,     el);
    chk("resp_ovf",    bus.resp_ovf,    eo);
    chk("resp_err",    bus.resp_err,    ee);
    chk("resp req_ready_0", bus.req_ready_0, 0);
    chk("resp req_ready_1", bus.req_ready_1, 0);
  endtask

  // Entered at a negedge with some request valid; returns at the negedge after the response handshake.
  task automatic serve(input int hold, input bit reassert);
    int w;
    logic [31:0] er;
    logic en, el, eo, ee;
    if (v[0] && v[1]) w = 1 - last_grant;
    else if (v[0])    w = 0;
    else              w = 1;
    apply();
    #1;
    chk("grant req_ready_0", bus.req_ready_0, w == 0);
    chk("grant req_ready_1", bus.req_ready_1, w == 1);
    model(op[w], sh[w], a[w], b[w], er, en, el, eo, ee);
    @(posedge clock);
    last_grant = w;
    @(negedge clock);
    chk("exec req_ready_0",  bus.req_ready_0,  0);
    chk("exec req_ready_1",  bus.req_ready_1,  0);
    chk("exec resp_valid_0", bus.resp_valid_0, 0);
    chk("exec resp_valid_1", bus.resp_valid_1, 0);
    v[w] = 1'b0;
    a[w] = $urandom;
    b[w] = $urandom;
    apply();
    @(negedge clock);
    chk_resp(w, er, en, el, eo, ee);
    for (int i = 0; i < hold; i++) begin
      rr[1-w] = 1'b1;
      apply();
      @(negedge clock);
      chk_resp(w, er, en, el, eo, ee);
    end
    rr[1-w] = 1'b0;
    rr[w]   = 1'b1;
    if (reassert) begin
      set_req(w, 5'($urandom_range(0, 5)), 5'($urandom), $urandom, $urandom);
    end
    apply();
    #1;
    chk("consume-cycle req_ready_owner", w ? bus.req_ready_1 : bus.req_ready_0, 0);
    @(negedge clock);
    rr[w] = 1'b0;
    apply();
    #1;
    chk("post resp_valid_0", bus.resp_valid_0, 0);
    chk("post resp_valid_1", bus.resp_valid_1, 0);
  endtask

  function automatic logic [4:0] rand_op();
    if ($urandom_range(0, 4) == 0) return 5'($urandom_range(6, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; op[i] = 0; sh[i] = 0; a[i] = 0; b[i] = 0; rr[i] = 0;
    end
    last_grant = 1;
    rst_n = 1'b0;
    set_req(0, 5'd0, 5'd0, 32'd1, 32'd2);
    set_req(1, 5'd0, 5'd0, 32'd3, 32'd4);
    apply();
    repeat (3) @(negedge clock);
    chk_quiet("reset");
    rst_n = 1'b1;

    // Contention from reset: requester 0 first, then 1, then a fresh pair goes to 0 again.
    set_req(0, 5'd1, 5'd0, 32'h8000_0000, 32'd1);
    set_req(1, 5'd1, 5'd0, 32'h8000_0000, 32'd1);
    serve(0, 0);
    serve(0, 0);
    set_req(0, 5'd1, 5'd0, 32'h8000_0000, 32'd1);
    set_req(1, 5'd1, 5'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    serve(0, 0);
    serve(0, 0);

    // Single add, then backpressure on requester 1 while requester 0 waits.
    set_req(0, 5'd0, 5'd0, 32'd5, 32'd7);
    serve(0, 0);
    set_req(1, 5'd4, 5'd4, 32'd1, 32'd0);
    set_req(0, 5'd3, 5'd0, 32'h00F0_0000, 32'h0000_000F);
    serve(10, 0);
    serve(0, 0);

    set_req(0, 5'd9, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    serve(0, 0);
    set_req(1, 5'd5, 5'd31, 32'h8000_0000, 32'd0);
    serve(0, 0);

    // Reset while an operation is in EXEC.
    set_req(0, 5'd0, 5'd0, 32'd10, 32'd20);
    set_req(1, 5'd0, 5'd0, 32'd30, 32'd40);
    apply();
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk_quiet("abort");
    @(negedge clock);
    chk_quiet("abort hold");
    rst_n = 1'b1;
    last_grant = 1;
    serve(0, 0);
    serve(0, 0);

    for (int n = 0; n < 40; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (!v[x] && $urandom_range(0, 1) == 1) begin
          set_req(x, rand_op(), 5'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0) ? a[x] : $urandom);
          if ($urandom_range(0, 3) == 0) b[x] = a[x];
        end
      end
      if (!v[0] && !v[1]) begin
        apply();
        #1;
        chk("idle req_ready_0", bus.req_ready_0, 0);
        chk("idle req_ready_1", bus.req_ready_1, 0);
        @(negedge clock);
      end else begin
        serve($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
